// File: rtl/fetch_stage_pkg.sv
// Shared definitions for the instruction-fetch stage: instruction sizing,
// nop encoding, fetch FSM state encodings and the sequential PC step.
`ifndef INSTR_SIZE
`define INSTR_SIZE 32
`endif
`ifndef INSTR_NOP
`define INSTR_NOP {`INSTR_SIZE{1'b0}}
`endif
`ifndef FETCH_ISSUE
`define FETCH_ISSUE 2'd0
`endif
`ifndef FETCH_WAIT
`define FETCH_WAIT 2'd1
`endif
`ifndef FETCH_HELD
`define FETCH_HELD 2'd2
`endif
`ifndef PC_INCR
`define PC_INCR 4
`endif

package fetch_stage_pkg;

  localparam int INSTR_SIZE = `INSTR_SIZE;
  localparam logic [INSTR_SIZE-1:0] INSTR_NOP = `INSTR_NOP;
  localparam int PC_INCR = `PC_INCR;

  typedef enum logic [1:0] {
    ST_ISSUE = `FETCH_ISSUE,
    ST_WAIT  = `FETCH_WAIT,
    ST_HELD  = `FETCH_HELD
  } fetch_state_e;

  // Word-align a fetch address by clearing the byte-offset bits.
  function automatic logic [1:0] byte_offset_mask();
    return 2'b00;
  endfunction

endpackage

// File: rtl/fetch_stage_chk.sv
// Protocol checker for the fetch stage: requests and responses only ever
// coincide with the WAIT state, since one request is outstanding at a time.
module fetch_stage_chk
  import fetch_stage_pkg::*;
(
  input logic       clk,
  input logic       rst,
  input logic       imem_req_i,
  input logic       imem_ready_i,
  input logic [1:0] state_i
);

  // A response in ISSUE or HELD is ignored by the FSM; flag it here.
  a_resp_only_in_wait: assert property (@(posedge clk) disable iff (rst)
    imem_ready_i |-> (state_i == ST_WAIT));

  a_req_only_in_wait: assert property (@(posedge clk) disable iff (rst)
    imem_req_i |-> (state_i == ST_WAIT));

endmodule

// File: rtl/fetch_stage_if_id_reg.sv
// IF/ID pipeline register: bubble wins over load, otherwise the contents hold.
// Reset and bubble both leave a nop with the valid bit cleared.
module fetch_stage_if_id_reg
  import fetch_stage_pkg::*;
#(
  parameter int PC_WIDTH = 32,
  parameter int INSTR_W  = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                load_i,
  input  logic                bubble_i,
  input  logic [INSTR_W-1:0]  instr_i,
  input  logic [PC_WIDTH-1:0] pcplus4_i,
  output logic [INSTR_W-1:0]  instr_o,
  output logic [PC_WIDTH-1:0] pcplus4_o,
  output logic                valid_o
);

  logic [INSTR_W-1:0]  instr_q;
  logic [PC_WIDTH-1:0] pcplus4_q;
  logic                valid_q;

  // IF/ID storage with bubble / load / hold selection
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      instr_q   <= INSTR_W'(INSTR_NOP);
      pcplus4_q <= {PC_WIDTH{1'b0}};
      valid_q   <= 1'b0;
    end else if (bubble_i) begin
      instr_q   <= INSTR_W'(INSTR_NOP);
      pcplus4_q <= {PC_WIDTH{1'b0}};
      valid_q   <= 1'b0;
    end else if (load_i) begin
      instr_q   <= instr_i;
      pcplus4_q <= pcplus4_i;
      valid_q   <= 1'b1;
    end else begin
      instr_q   <= instr_q;
      pcplus4_q <= pcplus4_q;
      valid_q   <= valid_q;
    end
  end

  assign instr_o   = instr_q;
  assign pcplus4_o = pcplus4_q;
  assign valid_o   = valid_q;

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: PC, single-outstanding imem request FSM with a
// one-entry skid for responses that land during a stall, and IF/ID loading.
module fetch_stage
  import fetch_stage_pkg::*;
#(
  parameter int                PC_WIDTH = 32,
  parameter int                INSTR_W  = 32,
  parameter logic [PC_WIDTH-1:0] RESET_PC = {PC_WIDTH{1'b0}}
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                pc_Stop,
  input  logic                redirect_Valid,
  input  logic [PC_WIDTH-1:0] redirect_Target,
  output logic                imem_Req,
  output logic [PC_WIDTH-1:0] imem_Addr,
  input  logic                imem_Ready,
  input  logic [INSTR_W-1:0]  imem_Rdata,
  output logic [INSTR_W-1:0]  id_Instr,
  output logic [PC_WIDTH-1:0] id_PcPlus4,
  output logic                id_Valid
);

  if (INSTR_W != INSTR_SIZE) begin : g_bad_instr_w
    $error("fetch_stage: INSTR_W must equal INSTR_SIZE");
  end

  localparam logic [PC_WIDTH-1:0] PC_STEP = PC_WIDTH'(PC_INCR);

  fetch_state_e        state_q;
  logic [PC_WIDTH-1:0] pc_q;
  logic [INSTR_W-1:0]  skid_q;
  logic                drop_q;
  logic                imem_req_q;
  logic [PC_WIDTH-1:0] imem_addr_q;

  logic [PC_WIDTH-1:0] pc_plus4_s;
  logic [PC_WIDTH-1:0] target_aligned_s;
  logic [1:0]          unused_target_lsb_s;
  logic                accept_s;
  logic                ifid_bubble_s;
  logic [INSTR_W-1:0]  ifid_instr_d;

  assign pc_plus4_s          = pc_q + PC_STEP;
  assign target_aligned_s    = {redirect_Target[PC_WIDTH-1:2], byte_offset_mask()};
  assign unused_target_lsb_s = redirect_Target[1:0];

  // Decide whether an instruction enters IF/ID this cycle and where it comes from
  always_comb begin
    accept_s     = 1'b0;
    ifid_instr_d = skid_q;
    if (redirect_Valid) begin
      accept_s     = 1'b0;
      ifid_instr_d = skid_q;
    end else if (pc_Stop) begin
      accept_s     = 1'b0;
      ifid_instr_d = skid_q;
    end else begin
      case (state_q)
        ST_WAIT: begin
          if (imem_Ready && !drop_q) begin
            accept_s     = 1'b1;
            ifid_instr_d = imem_Rdata;
          end else begin
            accept_s     = 1'b0;
            ifid_instr_d = skid_q;
          end
        end
        ST_HELD: begin
          accept_s     = 1'b1;
          ifid_instr_d = skid_q;
        end
        ST_ISSUE: begin
          accept_s     = 1'b0;
          ifid_instr_d = skid_q;
        end
        default: begin
          accept_s     = 1'b0;
          ifid_instr_d = skid_q;
        end
      endcase
    end
    ifid_bubble_s = redirect_Valid | (~pc_Stop & ~accept_s);
  end

  // Fetch FSM, PC, skid and the registered memory request
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_ISSUE;
      pc_q        <= RESET_PC;
      skid_q      <= INSTR_W'(INSTR_NOP);
      drop_q      <= 1'b0;
      imem_req_q  <= 1'b0;
      imem_addr_q <= {PC_WIDTH{1'b0}};
    end else if (redirect_Valid) begin
      pc_q       <= target_aligned_s;
      skid_q     <= INSTR_W'(INSTR_NOP);
      imem_req_q <= 1'b0;
      // An unanswered request must still be drained before the next one goes out.
      if ((state_q == ST_WAIT) && !imem_Ready) begin
        drop_q  <= 1'b1;
        state_q <= ST_WAIT;
      end else begin
        drop_q  <= 1'b0;
        state_q <= ST_ISSUE;
      end
    end else begin
      case (state_q)
        ST_ISSUE: begin
          imem_req_q  <= 1'b1;
          imem_addr_q <= pc_q;
          state_q     <= ST_WAIT;
        end
        ST_WAIT: begin
          imem_req_q <= 1'b0;
          if (imem_Ready && drop_q) begin
            drop_q  <= 1'b0;
            state_q <= ST_ISSUE;
          end else if (imem_Ready && pc_Stop) begin
            skid_q  <= imem_Rdata;
            state_q <= ST_HELD;
          end else if (accept_s) begin
            pc_q    <= pc_plus4_s;
            state_q <= ST_ISSUE;
          end else begin
            state_q <= ST_WAIT;
          end
        end
        ST_HELD: begin
          imem_req_q <= 1'b0;
          if (accept_s) begin
            pc_q    <= pc_plus4_s;
            state_q <= ST_ISSUE;
          end else begin
            state_q <= ST_HELD;
          end
        end
        default: begin
          imem_req_q <= 1'b0;
          drop_q     <= 1'b0;
          state_q    <= ST_ISSUE;
        end
      endcase
    end
  end

  assign imem_Req  = imem_req_q;
  assign imem_Addr = imem_addr_q;

  fetch_stage_if_id_reg #(
    .PC_WIDTH (PC_WIDTH),
    .INSTR_W  (INSTR_W)
  ) u_if_id (
    .clk       (clk),
    .rst       (rst),
    .load_i    (accept_s),
    .bubble_i  (ifid_bubble_s),
    .instr_i   (ifid_instr_d),
    .pcplus4_i (pc_plus4_s),
    .instr_o   (id_Instr),
    .pcplus4_o (id_PcPlus4),
    .valid_o   (id_Valid)
  );

  fetch_stage_chk u_chk (
    .clk          (clk),
    .rst          (rst),
    .imem_req_i   (imem_req_q),
    .imem_ready_i (imem_Ready),
    .state_i      (state_q)
  );

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- Instruction-fetch stage: owns the program counter, issues requests to the instruction memory, and loads the IF/ID pipeline register that feeds decode.
- Sits directly upstream of the hazard detection unit and consumes its pc_Stop stall.
- Supports multi-cycle instruction memory, stall, and a one-cycle redirect (jump/branch) with flush.

Parameters:
- PC_WIDTH, 32, width of program counter and memory address.
- INSTR_W, 32, instruction width; must equal `INSTR_SIZE.
- RESET_PC, 0, PC value loaded at reset.

Ports:
- clk  in  1  single clock; all state changes on rising edge.
- rst  in  1  reset, asynchronous, active-high.
- pc_Stop  in  1  stall from hazard unit; hold PC and IF/ID.
- redirect_Valid  in  1  one-cycle pulse; load new PC and flush.
- redirect_Target  in  PC_WIDTH  new PC; valid with redirect_Valid.
- imem_Req  out  1  request strobe to instruction memory.
- imem_Addr  out  PC_WIDTH  fetch address; valid while imem_Req=1.
- imem_Ready  in  1  response strobe; one cycle per request.
- imem_Rdata  in  INSTR_W  instruction; valid with imem_Ready.
- id_Instr  out  INSTR_W  IF/ID instruction to decode/hazard unit.
- id_PcPlus4  out  PC_WIDTH  IF/ID PC+4 of id_Instr.
- id_Valid  out  1  IF/ID holds a real instruction (0 = bubble).

Behaviour:
- Reset (async): pc=RESET_PC, state=ISSUE, skid empty, drop=0, imem_Req=0, imem_Addr=0, id_Instr=0 (nop), id_PcPlus4=0, id_Valid=0.
- Reset mid-request abandons it; instruction memory shares rst and drops it too.
- FSM states:
  - ISSUE: imem_Req=1, imem_Addr=pc for exactly one cycle, then WAIT.
  - WAIT: imem_Req=0; remain until imem_Ready.
  - HELD: response captured in skid register while stalled; no new request.
- Exactly one outstanding request at any time. Response latency is at least 1 cycle after the ISSUE cycle.
- WAIT with imem_Ready, drop=0:
  - pc_Stop=0: IF/ID <= {imem_Rdata, pc+4, 1}; pc <= pc+4; go ISSUE.
  - pc_Stop=1: skid <= imem_Rdata; go HELD.
- HELD with pc_Stop=0: IF/ID <= {skid, pc+4, 1}; pc <= pc+4; go ISSUE.
- IF/ID update priority, per cycle:
  1. redirect.
  2. pc_Stop=1: hold all IF/ID fields.
  3. instruction accepted: load it.
  4. otherwise: load bubble {0, 0, 0}.
- Redirect (redirect_Valid=1) has priority over stall and memory response:
  - pc <= redirect_Target; IF/ID <= bubble; skid cleared.
  - In ISSUE or HELD: go ISSUE.
  - In WAIT without imem_Ready: set drop=1, stay WAIT. The stale response is discarded, drop clears, then go ISSUE.
  - In WAIT with imem_Ready the same cycle: discard that response, go ISSUE.
- redirect_Target low two bits are ignored; the PC is forced word-aligned.
- PC arithmetic is modulo 2^PC_WIDTH; wrap from all-ones-minus-3 to 0 is silent.
- A response arriving in ISSUE or HELD is a protocol error: ignored, assertion fires in simulation.

Decomposition:
- Shared defs file gets:
  - `INSTR_SIZE reuse.
  - `INSTR_NOP (all zeros).
  - `FETCH_ISSUE / `FETCH_WAIT / `FETCH_HELD 2-bit state encodings.
  - `PC_INCR (4).
- One natural sub-module: if_id_reg, the IF/ID register with load/hold/bubble controls and async reset.
- FSM, PC and skid stay in fetch_stage.

Test Plan:
- Reset, 1-cycle memory: imem_Addr goes 0, 4, 8 on successive ISSUE cycles. id_Instr follows memory data with id_Valid=1 and id_PcPlus4=4, 8, 12.
- Stall: pc_Stop=1 for 3 cycles while instr@8 returns. IF/ID holds instr@4, data goes to HELD. On release, IF/ID=instr@8, next imem_Addr=12.
- Redirect in WAIT: redirect to 0x40 while 0x10 is outstanding. The 0x10 response is dropped and next imem_Addr=0x40. IF/ID shows a bubble, then instr@0x40 with id_PcPlus4=0x44.
- Redirect with stall in the same cycle: pc_Stop=1 and redirect_Valid=1 in HELD. IF/ID becomes a bubble (id_Valid=0), skid is discarded, next imem_Addr=target.
- Async reset asserted mid-WAIT: all outputs go to reset values with no clock edge. After release the first imem_Addr=RESET_PC.
- Wrap: pc=0xFFFFFFFC fetched, next imem_Addr=0x00000000, id_PcPlus4=0.
